// File: rtl/mv_pred_sequencer.sv
// Motion-vector predictor sequencer: walks blocks in raster order, fetches three
// neighbour vectors from the store, forms a component-wise median predictor, hands
// it to the search engine and writes the returned vector back.
// Optional build macro: MVSEQ_EDGE_ZERO_EN zeroes neighbours that fall off the
// left or top frame edge instead of using the store's clamped data.
module mv_pred_sequencer #(
    parameter int unsigned BLOCKS_X = 80,
    parameter int unsigned BLOCKS_Y = 45
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        feed,
    output logic        WE,
    output logic [13:0] curpos,
    output logic [13:0] MVector,
    input  logic [13:0] vecout,
    output logic        pred_valid,
    input  logic        pred_ready,
    output logic [13:0] pred_mv,
    input  logic        mv_valid,
    input  logic [13:0] mv_in
);

    localparam logic [6:0] XLast = 7'(BLOCKS_X - 1);
    localparam logic [6:0] YLast = 7'(BLOCKS_Y - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StPred,
        StWaitMv,
        StWrite,
        StAdv
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [13:0] n0_q, n0_d;
    logic [13:0] n1_q, n1_d;
    logic [13:0] curpos_q, curpos_d;
    logic [13:0] mvector_q, mvector_d;
    logic [13:0] pred_q, pred_d;

    logic [6:0]  x, y;
    logic        last_blk;
    logic [13:0] e0, e1, e2;

    assign x        = curpos_q[6:0];
    assign y        = curpos_q[13:7];
    assign last_blk = (x >= XLast) && (y >= YLast);

    function automatic logic [6:0] med3(input logic [6:0] a, input logic [6:0] b,
                                        input logic [6:0] c);
        logic signed [6:0] sa, sb, sc, lo, hi;
        sa = a;
        sb = b;
        sc = c;
        lo = (sa < sb) ? sa : sb;
        hi = (sa < sb) ? sb : sa;
        if (sc < lo) begin
            med3 = lo;
        end else if (sc > hi) begin
            med3 = hi;
        end else begin
            med3 = sc;
        end
    endfunction

    // Neighbour values as seen by the median; n2 arrives directly from the store in DRAIN.
`ifdef MVSEQ_EDGE_ZERO_EN
    assign e0 = (x == 7'd0) ? 14'd0 : n0_q;
    assign e1 = (y == 7'd0) ? 14'd0 : n1_q;
    assign e2 = (y == 7'd0) ? 14'd0 : vecout;
`else
    assign e0 = n0_q;
    assign e1 = n1_q;
    assign e2 = vecout;
`endif

    // State-decoded outputs; all low in IDLE so reset clears them on the next cycle.
    always_comb begin
        feed       = (state_q == StFetch);
        WE         = (state_q == StWrite);
        pred_valid = (state_q == StPred);
        busy       = (state_q != StIdle);
        frame_done = (state_q == StAdv) && last_blk;
        curpos     = curpos_q;
        MVector    = mvector_q;
        pred_mv    = pred_q;
    end

    // Next-state and datapath updates for the block walk.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n0_d      = n0_q;
        n1_d      = n1_q;
        curpos_d  = curpos_q;
        mvector_d = mvector_q;
        pred_d    = pred_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    curpos_d = 14'd0;
                    k_d      = 2'd0;
                    state_d  = StFetch;
                end
            end
            StFetch: begin
                // Store read latency is one cycle: k=1 returns left, k=2 returns top.
                if (k_q == 2'd1) n0_d = vecout;
                if (k_q == 2'd2) begin
                    n1_d    = vecout;
                    k_d     = 2'd0;
                    state_d = StDrain;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            StDrain: begin
                pred_d  = {med3(e0[13:7], e1[13:7], e2[13:7]),
                           med3(e0[6:0], e1[6:0], e2[6:0])};
                state_d = StPred;
            end
            StPred: begin
                if (pred_ready) state_d = StWaitMv;
            end
            StWaitMv: begin
                if (mv_valid) begin
                    mvector_d = mv_in;
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                state_d = StAdv;
            end
            StAdv: begin
                if (x < XLast) begin
                    curpos_d = {y, 7'(x + 7'd1)};
                    state_d  = StFetch;
                end else if (y < YLast) begin
                    curpos_d = {7'(y + 7'd1), 7'd0};
                    state_d  = StFetch;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            k_q       <= 2'd0;
            n0_q      <= 14'd0;
            n1_q      <= 14'd0;
            curpos_q  <= 14'd0;
            mvector_q <= 14'd0;
            pred_q    <= 14'd0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n0_q      <= n0_d;
            n1_q      <= n1_d;
            curpos_q  <= curpos_d;
            mvector_q <= mvector_d;
            pred_q    <= pred_d;
        end
    end

endmodule

// File: tb/tb_mv_pred_sequencer.sv
// Scoreboard bench for mv_pred_sequencer on a 4x2 block frame. A store/engine
// driver supplies neighbour data and search results; a monitor pops expected
// predictors and writes from queues whenever the DUT presents them.
module tb_mv_pred_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, pred_ready, mv_valid;
    logic        busy, frame_done, feed, WE, pred_valid;
    logic [13:0] curpos, MVector, vecout, pred_mv, mv_in;

    mv_pred_sequencer #(.BLOCKS_X(4), .BLOCKS_Y(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .feed       (feed),
        .WE         (WE),
        .curpos     (curpos),
        .MVector    (MVector),
        .vecout     (vecout),
        .pred_valid (pred_valid),
        .pred_ready (pred_ready),
        .pred_mv    (pred_mv),
        .mv_valid   (mv_valid),
        .mv_in      (mv_in)
    );

    always #5 clk = ~clk;

    // Per-block neighbour reads (left, top, top-right+1), search result, expected predictor.
    logic [13:0] nb0 [8];
    logic [13:0] nb1 [8];
    logic [13:0] nb2 [8];
    logic [13:0] mvt [8];
    logic [13:0] exp_p [8];

    logic [13:0] exp_pred [$];
    logic [27:0] exp_wr [$];

    int n_vec = 0;
    int n_bad = 0;
    int n_busy, n_we, n_done;
    logic inject_mv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input bit stall);
        logic [13:0] snap;
        bit seen;
        for (int b = 0; b < 8; b++) begin
            exp_pred.push_back(exp_p[b]);
            exp_wr.push_back({14'((b / 4) * 128 + (b % 4)), mvt[b]});
        end
        n_busy = 0;
        n_we   = 0;
        n_done = 0;
        pred_ready = !stall;
        pulse_start();
        if (stall) begin
            seen = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
                @(negedge clk);
                if (pred_valid) seen = 1'b1;
            end
            chk("stall_pred_valid_seen", 32'(seen), 32'd1);
            snap = pred_mv;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("stall_pred_valid", 32'(pred_valid), 32'd1);
                chk("stall_pred_mv", 32'(pred_mv), 32'(snap));
                chk("stall_no_we", 32'(WE), 32'd0);
                inject_mv = (i == 1);
                start     = (i == 3);
            end
            inject_mv  = 1'b0;
            start      = 1'b0;
            pred_ready = 1'b1;
        end
        seen = 1'b0;
        for (int t = 0; t < 1000 && !seen; t++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        chk("frame_done_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        chk("we_count", 32'(n_we), 32'd8);
        chk("done_count", 32'(n_done), 32'd1);
        if (!stall) chk("busy_cycles", 32'(n_busy), 32'd64);
        chk("pred_queue_empty", 32'(exp_pred.size()), 32'd0);
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        exp_pred.delete();
        exp_wr.delete();
    endtask

    initial begin
        nb0 = '{14'h0101, 14'h0081, 14'h0003, 14'h01FD, 14'h0105, 14'h203F, 14'h0005, 14'h3FFF};
        nb1 = '{14'h0101, 14'h0105, 14'h0005, 14'h3F02, 14'h0083, 14'h1FC0, 14'h0005, 14'h3F7E};
        nb2 = '{14'h0101, 14'h3F7F, 14'h0004, 14'h007F, 14'h0184, 14'h2040, 14'h3F7F, 14'h0000};
        mvt = '{14'h1234, 14'h0001, 14'h3FFF, 14'h2040, 14'h0A5A, 14'h1555, 14'h2AAA, 14'h0F0F};
`ifdef MVSEQ_EDGE_ZERO_EN
        exp_p = '{14'h0000, 14'h0000, 14'h0000, 14'h0000, 14'h0083, 14'h2040, 14'h0005,
                  14'h3FFF};
`else
        exp_p = '{14'h0101, 14'h0081, 14'h0004, 14'h007F, 14'h0104, 14'h2040, 14'h0005,
                  14'h3FFF};
`endif
        reset      = 1'b1;
        start      = 1'b0;
        pred_ready = 1'b1;
        inject_mv  = 1'b0;
        vecout     = 14'd0;
        mv_valid   = 1'b0;
        mv_in      = 14'd0;
        n_busy     = 0;
        n_we       = 0;
        n_done     = 0;

        fork
            // Store and search-engine model: decide at negedge, drive just after posedge.
            begin : driver
                int idx;
                idx = 0;
                forever begin
                    logic [13:0] nv, nmi;
                    logic nm;
                    int b;
                    @(negedge clk);
                    #2;
                    b = int'(curpos[7]) * 4 + int'(curpos[1:0]);
                    if (feed) begin
                        nv  = (idx == 0) ? nb0[b] : (idx == 1) ? nb1[b] : nb2[b];
                        idx = (idx < 2) ? idx + 1 : 2;
                    end else begin
                        nv  = 14'd0;
                        idx = 0;
                    end
                    nm  = (pred_valid && pred_ready) || inject_mv;
                    nmi = mvt[b];
                    @(posedge clk);
                    #1;
                    vecout   = nv;
                    mv_valid = nm;
                    mv_in    = nmi;
                end
            end
            // Monitor: compare predictor handshakes and store writes against the queues.
            begin : monitor
                forever begin
                    logic [13:0] ep;
                    logic [27:0] ew;
                    @(negedge clk);
                    #1;
                    if (busy) n_busy++;
                    if (frame_done) n_done++;
                    if (pred_valid && pred_ready) begin
                        if (exp_pred.size() == 0) begin
                            chk("pred_unexpected", 32'd1, 32'd0);
                        end else begin
                            ep = exp_pred.pop_front();
                            chk("pred_mv", 32'(pred_mv), 32'(ep));
                        end
                    end
                    if (WE) begin
                        n_we++;
                        chk("we_feed_low", 32'(feed), 32'd0);
                        if (exp_wr.size() == 0) begin
                            chk("write_unexpected", 32'd1, 32'd0);
                        end else begin
                            ew = exp_wr.pop_front();
                            chk("write_curpos", 32'(curpos), 32'(ew[27:14]));
                            chk("write_mvector", 32'(MVector), 32'(ew[13:0]));
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_feed", 32'(feed), 32'd0);
        chk("rst_we", 32'(WE), 32'd0);
        chk("rst_curpos", 32'(curpos), 32'd0);
        chk("rst_mvector", 32'(MVector), 32'd0);
        chk("rst_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_pred_mv", 32'(pred_mv), 32'd0);
        reset = 1'b0;

        // Reset during FETCH k=1, then start and reset together.
        begin
            bit seen;
            pulse_start();
            seen = feed;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                if (feed) seen = 1'b1;
            end
            chk("fetch_seen", 32'(seen), 32'd1);
            @(negedge clk);
            chk("fetch_k1_feed", 32'(feed), 32'd1);
            reset = 1'b1;
            start = 1'b1;
            @(negedge clk);
            chk("midrst_feed", 32'(feed), 32'd0);
            chk("midrst_busy", 32'(busy), 32'd0);
            chk("midrst_curpos", 32'(curpos), 32'd0);
            @(negedge clk);
            chk("start_rst_busy", 32'(busy), 32'd0);
            start = 1'b0;
            reset = 1'b0;
            repeat (2) @(negedge clk);
        end

        run_frame(1'b0);
        run_frame(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
